// File: rtl/telemetry_framer_pkg.sv
// Shared types and constants for the telemetry framer: FSM encoding, default
// framing bytes and elaboration-time parameter legality checks.
package telemetry_framer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StSeq,
    StPayload,
    StStatus,
    StCsum,
    StTrailer
  } state_e;

  localparam logic [7:0] DefaultHeader  = 8'h55;
  localparam logic [7:0] DefaultTrailer = 8'hAA;

  localparam int unsigned MaxFields     = 16;
  localparam int unsigned MaxFieldBytes = 4;

  function automatic bit params_ok(int unsigned num_fields, int unsigned field_bytes);
    return (num_fields >= 1) && (num_fields <= MaxFields) &&
           (field_bytes >= 1) && (field_bytes <= MaxFieldBytes);
  endfunction

  // Payload byte index width; never zero even for a single-byte payload.
  function automatic int unsigned idx_width(int unsigned num_bytes);
    return (num_bytes > 1) ? $clog2(num_bytes) : 1;
  endfunction

endpackage

// File: rtl/telemetry_framer_if.sv
// Sample/status inputs and byte-serial transmit outputs of the telemetry framer.
interface telemetry_framer_if #(
  parameter int unsigned NUM_FIELDS  = 4,
  parameter int unsigned FIELD_BYTES = 2
);
  logic                                continuous;
  logic                                sample_req;
  logic [NUM_FIELDS*FIELD_BYTES*8-1:0] sample_in;
  logic [7:0]                          status;
  logic                                tx_busy;
  logic [7:0]                          tx_byte;
  logic                                tx_strobe;
  logic                                pkt_active;
  logic [7:0]                          missed_cnt;

  modport master (
    input  continuous, sample_req, sample_in, status, tx_busy,
    output tx_byte, tx_strobe, pkt_active, missed_cnt
  );

  modport slave (
    output continuous, sample_req, sample_in, status, tx_busy,
    input  tx_byte, tx_strobe, pkt_active, missed_cnt
  );
endinterface

// File: rtl/telemetry_framer_byte_sel.sv
// Picks payload byte idx from the shadow vector: field 0 first, each field MSB first.
module tf_byte_sel #(
  parameter int unsigned NUM_FIELDS  = 4,
  parameter int unsigned FIELD_BYTES = 2,
  parameter int unsigned IdxW        = 3
) (
  input  logic [NUM_FIELDS*FIELD_BYTES*8-1:0] shadow,
  input  logic [IdxW-1:0]                     idx,
  output logic [7:0]                          sel_byte
);

  always_comb begin
    sel_byte = '0;
    for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
      for (int unsigned b = 0; b < FIELD_BYTES; b++) begin
        if (idx == IdxW'(f * FIELD_BYTES + b)) begin
          sel_byte = shadow[(f * FIELD_BYTES + FIELD_BYTES - 1 - b) * 8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/telemetry_framer.sv
// Packetizes captured samples into HEADER/SEQ/payload/STATUS/CSUM/TRAILER bytes,
// pacing output to at most one byte every other cycle and honouring tx_busy.
module telemetry_framer
  import telemetry_framer_pkg::*;
#(
  parameter int unsigned NUM_FIELDS   = 4,
  parameter int unsigned FIELD_BYTES  = 2,
  parameter logic [7:0]  HEADER_BYTE  = DefaultHeader,
  parameter logic [7:0]  TRAILER_BYTE = DefaultTrailer,
  parameter bit          CSUM_EN      = 1'b1
) (
  input logic               clk,
  input logic               rst,
  telemetry_framer_if.master bus
);

  localparam int unsigned NumBytes = NUM_FIELDS * FIELD_BYTES;
  localparam int unsigned SampleW  = NumBytes * 8;
  localparam int unsigned IdxW     = idx_width(NumBytes);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

  if (!params_ok(NUM_FIELDS, FIELD_BYTES)) begin : g_param_check
    $error("telemetry_framer: NUM_FIELDS must be 1..16 and FIELD_BYTES 1..4");
  end

  state_e              state_q;
  logic [SampleW-1:0]  sample_q, shadow_q;
  logic [7:0]          status_sh_q, seq_q, csum_q, missed_q, tx_byte_q;
  logic                pending_q, tx_strobe_q, pkt_active_q;
  logic [IdxW-1:0]     idx_q;
  logic [7:0]          payload_byte;
  logic                issue, hdr_issue;

  // A byte may only leave when the serializer is free and the last cycle was not a strobe.
  assign issue     = !bus.tx_busy && !tx_strobe_q;
  assign hdr_issue = issue && (state_q == StHeader);

  tf_byte_sel #(
    .NUM_FIELDS (NUM_FIELDS),
    .FIELD_BYTES(FIELD_BYTES),
    .IdxW       (IdxW)
  ) u_byte_sel (
    .shadow  (shadow_q),
    .idx     (idx_q),
    .sel_byte(payload_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sample_q     <= '0;
      shadow_q     <= '0;
      status_sh_q  <= '0;
      seq_q        <= '0;
      csum_q       <= '0;
      missed_q     <= '0;
      tx_byte_q    <= '0;
      pending_q    <= 1'b0;
      tx_strobe_q  <= 1'b0;
      pkt_active_q <= 1'b0;
      idx_q        <= '0;
    end else begin
      tx_strobe_q <= 1'b0;

      // A request coinciding with the header snapshot is not a miss: the old sample ships now.
      if (bus.sample_req) begin
        sample_q  <= bus.sample_in;
        pending_q <= 1'b1;
        if (pending_q && !hdr_issue && (missed_q != 8'hFF)) begin
          missed_q <= missed_q + 8'd1;
        end
      end else if (hdr_issue) begin
        pending_q <= 1'b0;
      end

      if (hdr_issue) begin
        shadow_q    <= sample_q;
        status_sh_q <= bus.status;
      end

      unique case (state_q)
        StIdle: begin
          pkt_active_q <= 1'b0;
          if (issue && (bus.continuous || pending_q)) state_q <= StHeader;
        end
        StHeader: if (issue) begin
          tx_byte_q    <= HEADER_BYTE;
          tx_strobe_q  <= 1'b1;
          pkt_active_q <= 1'b1;
          state_q      <= StSeq;
        end
        StSeq: if (issue) begin
          tx_byte_q   <= seq_q;
          tx_strobe_q <= 1'b1;
          csum_q      <= seq_q;
          idx_q       <= '0;
          state_q     <= StPayload;
        end
        StPayload: if (issue) begin
          tx_byte_q   <= payload_byte;
          tx_strobe_q <= 1'b1;
          csum_q      <= csum_q ^ payload_byte;
          idx_q       <= idx_q + 1'b1;
          if (idx_q == LastIdx) state_q <= StStatus;
        end
        StStatus: if (issue) begin
          tx_byte_q   <= status_sh_q;
          tx_strobe_q <= 1'b1;
          csum_q      <= csum_q ^ status_sh_q;
          state_q     <= CSUM_EN ? StCsum : StTrailer;
        end
        StCsum: if (issue) begin
          tx_byte_q   <= csum_q;
          tx_strobe_q <= 1'b1;
          state_q     <= StTrailer;
        end
        StTrailer: if (issue) begin
          tx_byte_q   <= TRAILER_BYTE;
          tx_strobe_q <= 1'b1;
          seq_q       <= seq_q + 8'd1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tx_byte    = tx_byte_q;
  assign bus.tx_strobe  = tx_strobe_q;
  assign bus.pkt_active = pkt_active_q;
  assign bus.missed_cnt = missed_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Scoreboard bench for telemetry_framer: expected bytes are queued when a packet is
// requested and checked as each tx_strobe appears.
module tb_telemetry_framer;

  localparam int unsigned NF = 4;
  localparam int unsigned FB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  telemetry_framer_if #(.NUM_FIELDS(NF), .FIELD_BYTES(FB)) bus ();

  telemetry_framer #(.NUM_FIELDS(NF), .FIELD_BYTES(FB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [63:0] sample;
    logic [7:0]  status;
    logic [7:0]  csum;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  seq_m;
  int          strobe_cnt = 0;
  bit          busy_mode = 1'b0;
  int          busy_cnt = 0;
  logic        prev_strobe = 1'b0;
  logic        busy_at_edge = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Expected packet; csum is derived from SEQ/payload/STATUS unless a fixed value is given.
  task automatic push_pkt(input logic [63:0] s, input logic [7:0] st, input bit fixed,
                          input logic [7:0] csum_v);
    logic [7:0] c, b;
    exp_q.push_back(8'h55);
    exp_q.push_back(seq_m);
    c = seq_m;
    for (int f = 0; f < int'(NF); f++) begin
      for (int k = int'(FB) - 1; k >= 0; k--) begin
        b = s[f*FB*8 + k*8 +: 8];
        exp_q.push_back(b);
        c ^= b;
      end
    end
    exp_q.push_back(st);
    c ^= st;
    exp_q.push_back(fixed ? csum_v : c);
    exp_q.push_back(8'hAA);
    seq_m++;
  endtask

  task automatic pulse_req(input logic [63:0] s);
    @(negedge clk);
    bus.sample_in  = s;
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
  endtask

  task automatic send_sample(input logic [63:0] s, input logic [7:0] st);
    bus.status = st;
    push_pkt(s, st, 1'b0, 8'h00);
    pulse_req(s);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.pkt_active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL %s: drain timeout, %0d bytes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_active(input string name);
    int n = 0;
    while (!bus.pkt_active && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_start"}, 64'(bus.pkt_active), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_byte"}, 64'(bus.tx_byte), 64'd0);
    check({name, "_tx_strobe"}, 64'(bus.tx_strobe), 64'd0);
    check({name, "_pkt_active"}, 64'(bus.pkt_active), 64'd0);
    check({name, "_missed_cnt"}, 64'(bus.missed_cnt), 64'd0);
  endtask

  always @(posedge clk) busy_at_edge <= bus.tx_busy;

  // Serializer model: busy for 5 cycles after every strobe when enabled.
  always @(negedge clk) begin
    if (!busy_mode) busy_cnt = 0;
    else if (bus.tx_strobe) busy_cnt = 5;
    bus.tx_busy = busy_mode && (busy_cnt != 0);
    if (busy_cnt != 0) busy_cnt--;
  end

  always @(negedge clk) begin
    if (bus.tx_strobe) begin
      strobe_cnt++;
      check("pkt_active_on_strobe", 64'(bus.pkt_active), 64'd1);
      check("strobe_while_busy", 64'(busy_at_edge), 64'd0);
      check("back_to_back_strobe", 64'(prev_strobe), 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %0h, expected no byte", bus.tx_byte);
      end else begin
        check("tx_byte", 64'(bus.tx_byte), 64'(exp_q.pop_front()));
      end
    end
    prev_strobe = bus.tx_strobe;
  end

  initial begin
    vec_t vecs[4];
    int   n;
    int   base;

    vecs[0] = '{64'h1122_3344_5566_7788, 8'h80, 8'h08};
    vecs[1] = '{64'h0000_0000_0000_0000, 8'h00, 8'h01};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'hFD};
    vecs[3] = '{64'h0001_0203_0405_0607, 8'h5A, 8'h59};

    rst = 1'b1;
    bus.continuous = 1'b0;
    bus.sample_req = 1'b0;
    bus.sample_in  = '0;
    bus.status     = 8'h00;
    seq_m          = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Table: one packet per vector, SEQ 0..3 with hand-computed checksums.
    for (int i = 0; i < 4; i++) begin
      bus.status = vecs[i].status;
      push_pkt(vecs[i].sample, vecs[i].status, 1'b1, vecs[i].csum);
      pulse_req(vecs[i].sample);
      wait_drain($sformatf("table_%0d", i));
      check($sformatf("table_%0d_idle", i), 64'(bus.pkt_active), 64'd0);
    end

    // Inputs churn mid-packet; payload must be the captured value.
    send_sample(64'hDEAD_BEEF_0123_4567, 8'h11);
    n = 0;
    while (!bus.pkt_active && n < 50) begin
      bus.sample_in = {$urandom, $urandom};
      @(negedge clk);
      n++;
    end
    while (bus.pkt_active && n < 200) begin
      bus.sample_in = {$urandom, $urandom};
      bus.status    = 8'($urandom);
      @(negedge clk);
      n++;
    end
    wait_drain("churn");

    // Three requests inside one packet: two misses, third sample goes next.
    send_sample(64'hA0A1_A2A3_A4A5_A6A7, 8'h40);
    wait_active("miss");
    pulse_req(64'hB0B1_B2B3_B4B5_B6B7);
    pulse_req(64'hC0C1_C2C3_C4C5_C6C7);
    pulse_req(64'hD0D1_D2D3_D4D5_D6D7);
    push_pkt(64'hD0D1_D2D3_D4D5_D6D7, 8'h40, 1'b0, 8'h00);
    wait_drain("miss");
    check("missed_cnt_after_three", 64'(bus.missed_cnt), 64'd2);

    // Request landing on the header issue edge: old value ships, new one follows, no miss.
    push_pkt(64'hE0E1_E2E3_E4E5_E6E7, 8'h40, 1'b0, 8'h00);
    push_pkt(64'hF0F1_F2F3_F4F5_F6F7, 8'h40, 1'b0, 8'h00);
    pulse_req(64'hE0E1_E2E3_E4E5_E6E7);
    pulse_req(64'hF0F1_F2F3_F4F5_F6F7);
    wait_drain("hdr_collide");
    check("missed_cnt_hdr_collide", 64'(bus.missed_cnt), 64'd2);

    // Slow serializer: busy 5 cycles after each strobe.
    @(negedge clk);
    busy_mode = 1'b1;
    send_sample(64'h0F1E_2D3C_4B5A_6978, 8'h99);
    wait_drain("busy");
    busy_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during payload byte 3 abandons the packet.
    base = strobe_cnt;
    send_sample(64'h1357_9BDF_2468_ACE0, 8'h22);
    n = 0;
    while (strobe_cnt < base + 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_payload_3", 64'(strobe_cnt - base), 64'd6);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    exp_q.delete();
    seq_m = 8'h00;
    rst   = 1'b0;
    send_sample(64'h8877_6655_4433_2211, 8'h33);
    wait_drain("post_rst");

    // Continuous mode from a clean reset: 300 packets, SEQ wraps, zero payload.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    seq_m = 8'h00;
    bus.status = 8'h3C;
    for (int p = 0; p < 300; p++) push_pkt(64'h0, 8'h3C, 1'b0, 8'h00);
    bus.continuous = 1'b1;
    n = 0;
    while (exp_q.size() >= 13 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    bus.continuous = 1'b0;
    check("continuous_progress", 64'(exp_q.size() < 13), 64'd1);
    wait_drain("continuous");
    check("continuous_missed", 64'(bus.missed_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
